fmap_reader_2: RTL and testbench
================================

Name: fmap_reader_2

Overview:
- Downstream neighbour of the layer-2 feature-map writer.
- After the writer finishes filling the dual-port feature-map RAM through port a, this block reads the map back through port b.
- It streams the map to the next convolution layer over a valid/ready handshake, once per output kernel pass.
- It absorbs the 1-cycle RAM read latency and downstream backpressure with a 2-entry skid FIFO.

Parameters:
- DATA_WIDTH, 16, feature-map word width.
- POOL_ADDR_WIDTH, 10, RAM port-b address width.
- FMAP_W, 12, map width in words; must be >= 1.
- FMAP_H, 12, map height in rows; must be >= 1.
- NUM_PASSES, 4, full-map replays per start (one per next-layer kernel); must be >= 1.
- Constraint: FMAP_W*FMAP_H <= 2**POOL_ADDR_WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- start  in  1  single-cycle pulse from the writer side; map is complete.
- q_b  in  DATA_WIDTH  RAM port-b read data; valid the cycle after rden_b.
- rden_b  out  1  RAM port-b read enable.
- wren_b  out  1  constant 0.
- address_b_t  out  POOL_ADDR_WIDTH  RAM port-b address.
- data_out  out  DATA_WIDTH  stream data.
- valid_out  out  1  stream valid.
- ready_in  in  1  stream ready from the next layer.
- row_last  out  1  qualifies data_out as the last word of a row.
- map_last  out  1  qualifies data_out as the last word of the final pass.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the final word has been accepted downstream.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; address, pass counter, FIFO and in-flight flag are cleared.
  - Outputs are 0: rden_b, address_b_t, valid_out, row_last, map_last, busy, done, data_out.
  - Reset mid-stream discards all data; no done pulse is generated.
- FSM:
  - IDLE -> READ on start; busy goes to 1 the next cycle.
  - READ -> DRAIN in the cycle after the last address of the last pass is issued.
  - DRAIN -> DONE when the FIFO is empty and no read is in flight.
  - DONE -> IDLE after one cycle; done=1 only while in DONE.
- start is ignored outside IDLE.
- Issue rule (combinational):
  - pop = valid_out & ready_in.
  - rden_b = (state==READ) & (occupancy + inflight - pop < 2).
  - address_b_t holds the current address register; the RAM samples it on the same edge as rden_b.
- Registered state:
  - inflight <= rden_b each cycle.
  - When inflight==1, q_b is pushed into the FIFO together with its row_last/map_last tags, which are computed at issue time and pipelined one stage.
- Address sequence:
  - Address starts at 0 and increments by 1 on each issue.
  - At FMAP_W*FMAP_H-1 it wraps to 0 and the pass counter increments.
  - The pass counter saturates at NUM_PASSES-1 and is cleared when done is generated.
- Tags:
  - row_last = 1 when the column counter reaches FMAP_W-1 (a separate counter, no divide).
  - map_last = 1 on the final address of pass NUM_PASSES-1.
- Latency and throughput:
  - start sampled at edge E0 -> rden_b=1 with address 0 during the next cycle -> valid_out=1 after edge E2.
  - With ready_in held at 1, one word is delivered per cycle with no bubbles.
- FIFO:
  - Depth 2; never overflows by construction; an overflow is an assertion failure.
  - data_out, row_last and map_last must stay stable while valid_out=1 and ready_in=0.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged.
- Total words per start = FMAP_W*FMAP_H*NUM_PASSES; done follows acceptance of the map_last word by exactly 1 cycle.

Decomposition:
- Shared package (the existing parameter header):
  - DATA_WIDTH, POOL_ADDR_WIDTH, FMAP_W, FMAP_H, NUM_PASSES.
  - Derived MAP_WORDS = FMAP_W*FMAP_H.
  - FSM state encodings: IDLE, READ, DRAIN, DONE.
- One sub-module, skid_fifo_2:
  - 2-entry FIFO with DATA_WIDTH+2 bits (data plus the two tags).
  - Provides push, pop, occupancy, and head outputs.
  - Same clock and same synchronous active-low reset.

Test Plan:
- Full stream: FMAP_W=4, FMAP_H=3, NUM_PASSES=2, RAM[i]=i+100, ready_in=1, pulse start.
  - Exactly 24 words: 100..111 twice, back-to-back.
  - row_last on words 4, 8, 12 of each pass.
  - map_last only on word 24; done 1 cycle later; busy low after done.
- Backpressure: same config with ready_in=0 for cycles 5-9 after start.
  - rden_b drops within 1 cycle; no word lost or duplicated.
  - Outputs stable while stalled; FIFO occupancy never exceeds 2.
- Random ready_in at 50% for 1000 cycles: output sequence identical to the full-stream case.
- start pulsed again while busy=1: ignored, still exactly 24 words and one done pulse.
- reset=0 for 1 cycle at word 7:
  - All outputs 0 the next cycle; no done pulse.
  - A new start replays from address 0, pass 0.
- Corner case FMAP_W=1, FMAP_H=1, NUM_PASSES=1: a single word carrying both row_last=1 and map_last=1; done follows.

Source files
------------

// File: rtl/fmap_reader_2_pkg.sv
// Shared feature-map geometry defaults, derived sizes and reader FSM encoding.
package fmap_reader_2_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int POOL_ADDR_WIDTH = 10;
  localparam int FMAP_W          = 12;
  localparam int FMAP_H          = 12;
  localparam int NUM_PASSES      = 4;
  localparam int MAP_WORDS       = FMAP_W * FMAP_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width that stays legal (>= 1 bit) for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_fifo_2.sv
// Two-entry FIFO, head visible combinationally; data appears the cycle after push.
// Pop and push may coincide; writer must never push into a full FIFO without popping.
module skid_fifo_2 #(
  parameter int WIDTH = 18
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head_dat
);

  logic [WIDTH-1:0] r_ent0;
  logic [WIDTH-1:0] r_ent1;
  logic [1:0]       r_occ;

  // Entry 0 is always the head; pops shift entry 1 forward.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_ent0 <= i_push_dat;
          else               r_ent1 <= i_push_dat;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_push_dat;
          end else begin
            r_ent0 <= i_push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ      = r_occ;
  assign o_head_dat = r_ent0;

  a_no_overflow : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    !(i_push && !i_pop && r_occ == 2'd2));
  a_no_underflow : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    !(i_pop && r_occ == 2'd0));

endmodule

// File: rtl/fmap_reader_2.sv
// Replays the feature map from RAM port b NUM_PASSES times as a valid/ready stream.
// First word valid 2 cycles after start; reads throttle so the 2-entry skid FIFO never overflows.
module fmap_reader_2 #(
  parameter int DATA_WIDTH      = fmap_reader_2_pkg::DATA_WIDTH,
  parameter int POOL_ADDR_WIDTH = fmap_reader_2_pkg::POOL_ADDR_WIDTH,
  parameter int FMAP_W          = fmap_reader_2_pkg::FMAP_W,
  parameter int FMAP_H          = fmap_reader_2_pkg::FMAP_H,
  parameter int NUM_PASSES      = fmap_reader_2_pkg::NUM_PASSES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      q_b,
  output logic                       rden_b,
  output logic                       wren_b,
  output logic [POOL_ADDR_WIDTH-1:0] address_b_t,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       row_last,
  output logic                       map_last,
  output logic                       busy,
  output logic                       done
);

  import fmap_reader_2_pkg::*;

  localparam int MAP_N = FMAP_W * FMAP_H;
  localparam int PW    = cnt_width(NUM_PASSES);
  localparam int CW    = cnt_width(FMAP_W);
  localparam int FW    = DATA_WIDTH + 2;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [POOL_ADDR_WIDTH-1:0] r_addr;
  logic [PW-1:0]              r_pass;
  logic [CW-1:0]              r_col;
  logic                       r_inflight;
  logic                       r_tag_row;
  logic                       r_tag_map;
  logic                       w_pop;
  logic                       w_rden;
  logic                       w_addr_wrap;
  logic                       w_row_end;
  logic                       w_last_issue;
  logic                       w_drained;
  logic [2:0]                 w_pending;
  logic [1:0]                 w_occ;
  logic [FW-1:0]              w_head;

  assign valid_out    = (w_occ != 2'd0);
  assign w_pop        = valid_out & ready_in;
  // Words already owed to the FIFO after this cycle's pop; issue only if one slot remains.
  assign w_pending    = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rden       = (r_state == ST_READ) && (w_pending < 3'd2);
  assign w_addr_wrap  = (r_addr == POOL_ADDR_WIDTH'(MAP_N - 1));
  assign w_row_end    = (r_col == CW'(FMAP_W - 1));
  assign w_last_issue = w_rden && w_addr_wrap && (r_pass == PW'(NUM_PASSES - 1));
  // Counts this cycle's pop so done lands exactly one cycle after the last acceptance.
  assign w_drained    = !r_inflight && ((w_occ - {1'b0, w_pop}) == 2'd0);

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)        w_state_nxt = ST_READ;
      ST_READ:  if (w_last_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drained)    w_state_nxt = ST_DONE;
      ST_DONE:                    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rden_b = w_rden;
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr     <= '0;
      r_pass     <= '0;
      r_col      <= '0;
      r_inflight <= 1'b0;
      r_tag_row  <= 1'b0;
      r_tag_map  <= 1'b0;
    end else begin
      r_inflight <= w_rden;
      r_tag_row  <= w_rden & w_row_end;
      r_tag_map  <= w_last_issue;
      if (w_rden) begin
        r_addr <= w_addr_wrap ? '0 : r_addr + POOL_ADDR_WIDTH'(1);
        r_col  <= w_row_end ? '0 : r_col + CW'(1);
        if (w_addr_wrap && (r_pass != PW'(NUM_PASSES - 1))) r_pass <= r_pass + PW'(1);
      end
      if (r_state == ST_DONE) begin
        r_addr <= '0;
        r_pass <= '0;
        r_col  <= '0;
      end
    end
  end

  skid_fifo_2 #(
    .WIDTH(FW)
  ) u_fifo (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_push    (r_inflight),
    .i_push_dat({q_b, r_tag_row, r_tag_map}),
    .i_pop     (w_pop),
    .o_occ     (w_occ),
    .o_head_dat(w_head)
  );

  assign address_b_t = r_addr;
  assign wren_b      = 1'b0;
  assign data_out    = valid_out ? w_head[FW-1:2] : '0;
  assign row_last    = valid_out & w_head[1];
  assign map_last    = valid_out & w_head[0];

endmodule

// File: tb/tb_fmap_reader_2.sv
// Bench for fmap_reader_2: a 4x3x2 instance and a 1x1x1 corner instance against a nested-loop stream model.
module tb_fmap_reader_2;

  localparam int W = 4, H = 3, P = 2, N = W * H;

  typedef struct packed {
    logic [15:0] d;
    logic        r;
    logic        m;
  } word_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        start = 1'b0, ready_in = 1'b0;
  logic [15:0] q_b = '0, data_out;
  logic        rden_b, wren_b, valid_out, row_last, map_last, busy, done;
  logic [9:0]  address_b_t;

  logic        start1 = 1'b0, ready1 = 1'b0;
  logic [15:0] q_b1 = '0, data_out1;
  logic        rden_b1, wren_b1, valid_out1, row_last1, map_last1, busy1, done1;
  logic [9:0]  address_b_t1;

  fmap_reader_2 #(.DATA_WIDTH(16), .POOL_ADDR_WIDTH(10), .FMAP_W(W), .FMAP_H(H), .NUM_PASSES(P)) dut (
    .clock(clock), .reset(reset), .start(start), .q_b(q_b), .rden_b(rden_b), .wren_b(wren_b),
    .address_b_t(address_b_t), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .row_last(row_last), .map_last(map_last), .busy(busy), .done(done));

  fmap_reader_2 #(.DATA_WIDTH(16), .POOL_ADDR_WIDTH(10), .FMAP_W(1), .FMAP_H(1), .NUM_PASSES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .q_b(q_b1), .rden_b(rden_b1), .wren_b(wren_b1),
    .address_b_t(address_b_t1), .data_out(data_out1), .valid_out(valid_out1), .ready_in(ready1),
    .row_last(row_last1), .map_last(map_last1), .busy(busy1), .done(done1));

  logic [15:0] ram [0:N-1];
  logic [15:0] ram1 = '0;

  always @(posedge clock) begin
    if (rden_b)  q_b  <= ram[int'(address_b_t)];
    if (rden_b1) q_b1 <= ram1;
  end

  int n_cmp = 0, n_bad = 0;
  word_t exp_q[$];
  word_t got_q[$];
  int    got_cyc[$];
  int    cyc = 0, done_cnt = 0, done_cyc = -1, last_map_cyc = -100, stall_err = 0, max_occ = 0;
  logic  pv = 1'b0, pr = 1'b0, pres = 1'b0;
  word_t pw = '0;

  // Monitor: acceptances, done pulses, stability of a stalled head, FIFO fill level.
  always @(negedge clock) begin
    word_t cur;
    cyc++;
    cur = {data_out, row_last, map_last};
    if (pres && reset && pv && !pr && (!valid_out || cur !== pw)) stall_err++;
    if (valid_out && ready_in) begin
      got_q.push_back(cur);
      got_cyc.push_back(cyc);
      if (map_last) last_map_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(dut.u_fifo.o_occ) > max_occ) max_occ = int'(dut.u_fifo.o_occ);
    pv = valid_out; pr = ready_in; pw = cur; pres = reset;
  end

  task automatic clear_mon();
    got_q.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; last_map_cyc = -100; stall_err = 0; max_occ = 0;
  endtask

  task automatic fill_ram(input bit incrementing);
    for (int i = 0; i < N; i++) ram[i] = incrementing ? 16'(i + 100) : 16'($urandom);
  endtask

  // Expected stream: P passes of the map in raster order with row/map end flags.
  task automatic build_model();
    word_t w;
    exp_q.delete();
    for (int p = 0; p < P; p++)
      for (int i = 0; i < N; i++) begin
        w.d = ram[i];
        w.r = ((i % W) == W - 1);
        w.m = (p == P - 1) && (i == N - 1);
        exp_q.push_back(w);
      end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready, output bit seen);
    int k;
    k = 0; seen = 1'b0;
    while (!seen && k < budget) begin
      if (rnd_ready) ready_in = 1'($urandom_range(0, 1));
      @(negedge clock);
      seen = done;
      k++;
      @(posedge clock); #1;
    end
    ready_in = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({rden_b, wren_b, address_b_t, data_out, valid_out, row_last, map_last, busy, done} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=0",
        {rden_b, wren_b, address_b_t, data_out, valid_out, row_last, map_last, busy, done});
    end
    n_cmp++;
    if ({rden_b1, wren_b1, address_b_t1, data_out1, valid_out1, row_last1, map_last1, busy1, done1} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_1x1 got=%h want=0",
        {rden_b1, wren_b1, address_b_t1, data_out1, valid_out1, row_last1, map_last1, busy1, done1});
    end
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || rden_b !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset busy=%b rden=%b want 0 0", busy, rden_b);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full_stream();
    bit seen;
    fill_ram(1'b1); build_model(); ready_in = 1'b1; clear_mon();
    pulse_start();
    @(negedge clock);
    n_cmp++;
    if (rden_b !== 1'b1 || address_b_t !== 10'd0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL first_issue rden=%b addr=%0d busy=%b want 1 0 1", rden_b, address_b_t, busy);
    end
    @(negedge clock);
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL early_valid got=%b want 0", valid_out); end
    @(negedge clock);
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== 16'd100) begin
      n_bad++; $display("FAIL first_word valid=%b data=%0d want 1 100", valid_out, data_out);
    end
    @(posedge clock); #1;
    wait_done(200, 1'b0, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL full_done_timeout got=0 want=1"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL full_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL full_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
      n_cmp++;
      if (got_cyc[i] - got_cyc[0] != i) begin
        n_bad++; $display("FAIL full_gap[%0d] got=%0d want=%0d", i, got_cyc[i] - got_cyc[0], i);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != last_map_cyc + 1) begin
      n_bad++; $display("FAIL full_done pulses=%0d at=%0d want 1 at %0d", done_cnt, done_cyc, last_map_cyc + 1);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL full_idle busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    bit seen;
    fill_ram(1'b0); build_model(); ready_in = 1'b1; clear_mon();
    pulse_start();
    for (int n = 1; n <= 12; n++) begin
      ready_in = !(n >= 5 && n <= 9);
      @(negedge clock);
      if (n >= 6 && n <= 9) begin
        n_cmp++;
        if (rden_b !== 1'b0) begin n_bad++; $display("FAIL bp_rden_c%0d got=%b want=0", n, rden_b); end
      end
      @(posedge clock); #1;
    end
    ready_in = 1'b1;
    wait_done(200, 1'b0, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stall_err != 0) begin n_bad++; $display("FAIL bp_stable got=%0d changes want=0", stall_err); end
    n_cmp++;
    if (max_occ > 2) begin n_bad++; $display("FAIL bp_occupancy got=%0d want<=2", max_occ); end
  endtask

  task automatic test_random_ready();
    bit seen;
    for (int run = 0; run < 3; run++) begin
      fill_ram(run == 0); build_model(); clear_mon();
      pulse_start();
      wait_done(330, 1'b1, seen);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rnd%0d_done_timeout got=0 want=1", run); end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", run, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rnd%0d_word[%0d] got=%h want=%h", run, i, got_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (stall_err != 0 || max_occ > 2) begin
        n_bad++; $display("FAIL rnd%0d_stall changes=%0d occ=%0d want 0 <=2", run, stall_err, max_occ);
      end
      n_cmp++;
      if (done_cnt != 1 || done_cyc != last_map_cyc + 1) begin
        n_bad++; $display("FAIL rnd%0d_done pulses=%0d at=%0d want 1 at %0d", run, done_cnt, done_cyc, last_map_cyc + 1);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int k;
    bit seen;
    fill_ram(1'b0); build_model(); ready_in = 1'b1; clear_mon();
    pulse_start();
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      start = (k == 2 || k == 9);
      @(negedge clock);
      seen = done;
      k++;
      @(posedge clock); #1;
    end
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL restart_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL restart_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL restart_done pulses=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    bit seen;
    fill_ram(1'b0); build_model(); ready_in = 1'b1; clear_mon();
    pulse_start();
    k = 0;
    while (got_q.size() < 7 && k < 50) begin @(posedge clock); #1; k++; end
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    clear_mon();
    @(negedge clock);
    n_cmp++;
    if ({rden_b, address_b_t, data_out, valid_out, row_last, map_last, busy, done} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs got=%h want=0",
        {rden_b, address_b_t, data_out, valid_out, row_last, map_last, busy, done});
    end
    repeat (20) @(posedge clock);
    #1;
    n_cmp++;
    if (done_cnt != 0 || got_q.size() != 0) begin
      n_bad++; $display("FAIL midrst_quiet done=%0d words=%0d want 0 0", done_cnt, got_q.size());
    end
    clear_mon();
    pulse_start();
    wait_done(200, 1'b0, seen);
    n_cmp++;
    if (!seen || got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL midrst_replay done=%b count=%0d want 1 %0d", seen, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL midrst_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_word();
    int cnt, acc_c, done_c, c;
    word_t w, want;
    ram1 = 16'($urandom); ready1 = 1'b1;
    want = {ram1, 1'b1, 1'b1};
    cnt = 0; acc_c = -1; done_c = -1; w = '0;
    @(posedge clock); #1 start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    for (c = 0; c < 20; c++) begin
      @(negedge clock);
      if (valid_out1 && ready1) begin cnt++; acc_c = c; w = {data_out1, row_last1, map_last1}; end
      if (done1) done_c = c;
    end
    @(posedge clock); #1;
    n_cmp++;
    if (cnt != 1) begin n_bad++; $display("FAIL single_count got=%0d want=1", cnt); end
    n_cmp++;
    if (w !== want) begin n_bad++; $display("FAIL single_word got=%h want=%h", w, want); end
    n_cmp++;
    if (done_c != acc_c + 1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL single_done at=%0d busy=%b want %0d 0", done_c, busy1, acc_c + 1);
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_random_ready();
    test_restart_ignored();
    test_mid_reset();
    test_single_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached without summary");
    $fatal(1, "bench timeout");
  end

endmodule
